lift_call_panel: RTL and testbench

Request front-end for the lift controller. It takes the raw floor-call buttons, synchronises and debounces them, and latches the pending calls, which also drive the indicator LEDs. It chooses the next target floor with a SCAN (sweep) policy and offers it to the lift controller over a valid/ack handshake. The lift controller then reports arrival back to this block. This block is the initiator; the lift controller is the responder.

---
 rtl/lift_call_panel_if.sv | 25 ++
 rtl/lift_call_panel.sv | 189 ++++++++++++++++++
 tb/tb_lift_call_panel.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lift_call_panel_if.sv
// Target handshake between the call panel (initiator)
// and the lift controller (responder).
interface lift_call_panel_if;
  logic [2:0] target;
  logic       target_valid;
  logic       target_ack;
  logic       arrived;
  logic [2:0] cur_floor;

  modport master (
    output target,
    output target_valid,
    input  target_ack,
    input  arrived,
    input  cur_floor
  );

  modport slave (
    input  target,
    input  target_valid,
    output target_ack,
    output arrived,
    output cur_floor
  );
endinterface

// File: rtl/lift_call_panel.sv
// Floor-call front-end: sync, debounce, latch calls,
// SCAN target selection and valid/ack offer to the lift.
module lift_call_panel #(
  parameter int FLOORS          = 7,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLOORS-1:0]  btn,
  lift_call_panel_if.master  lift,
  output logic [FLOORS-1:0]  pending,
  output logic               dir_up
);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    BUSY
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] FTOP = 3'(FLOORS);

  logic [FLOORS-1:0] sync1;
  logic [FLOORS-1:0] sync2;
  logic [FLOORS-1:0] db;
  logic [FLOORS-1:0] db_d;
  logic [FLOORS-1:0] press;
  logic [FLOORS-1:0] clr;
  logic [CNT_W-1:0]  cnt [FLOORS];

  state_t     state;
  state_t     state_n;
  logic [2:0] target_q;
  logic [2:0] target_n;
  logic       valid_q;
  logic       valid_n;
  logic       dir_n;
  logic [2:0] cf;
  logic [2:0] ge_f;
  logic [2:0] gt_f;
  logic [2:0] le_f;
  logic [2:0] lt_f;
  logic [2:0] sel;
  logic       sel_dir;

  assign lift.target       = target_q;
  assign lift.target_valid = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // A level must differ for DEBOUNCE_CYCLES cycles to flip db.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < FLOORS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      db_d <= db;
      for (int i = 0; i < FLOORS; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press = db & ~db_d;

  always_comb begin
    cf = lift.cur_floor;
    if (cf == 3'd0) begin
      cf = 3'd1;
    end else if (cf > FTOP) begin
      cf = FTOP;
    end
  end

  // Descending scan keeps the lowest hit, ascending the highest.
  always_comb begin
    ge_f = '0;
    gt_f = '0;
    le_f = '0;
    lt_f = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && 3'(i + 1) >= cf) ge_f = 3'(i + 1);
      if (pending[i] && 3'(i + 1) > cf)  gt_f = 3'(i + 1);
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (pending[i] && 3'(i + 1) <= cf) le_f = 3'(i + 1);
      if (pending[i] && 3'(i + 1) < cf)  lt_f = 3'(i + 1);
    end
  end

  always_comb begin
    sel     = '0;
    sel_dir = dir_up;
    if (dir_up) begin
      if (ge_f != 3'd0) begin
        sel = ge_f;
      end else begin
        sel     = lt_f;
        sel_dir = 1'b0;
      end
    end else begin
      if (le_f != 3'd0) begin
        sel = le_f;
      end else begin
        sel     = gt_f;
        sel_dir = 1'b1;
      end
    end
  end

  always_comb begin
    clr = '0;
    if (state == BUSY && lift.arrived) begin
      for (int i = 0; i < FLOORS; i++) begin
        if (target_q == 3'(i + 1)) clr[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    target_n = target_q;
    valid_n  = valid_q;
    dir_n    = dir_up;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          target_n = sel;
          valid_n  = 1'b1;
          dir_n    = sel_dir;
          state_n  = OFFER;
        end
      end
      OFFER: begin
        if (lift.target_ack) begin
          valid_n = 1'b0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (lift.arrived) begin
          target_n = '0;
          state_n  = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      target_q <= '0;
      valid_q  <= 1'b0;
      dir_up   <= 1'b1;
      pending  <= '0;
    end else begin
      state    <= state_n;
      target_q <= target_n;
      valid_q  <= valid_n;
      dir_up   <= dir_n;
      pending  <= (pending | press) & ~clr;
    end
  end

endmodule

// File: tb/tb_lift_call_panel.sv
// Scoreboard bench for lift_call_panel: directed scenarios
// plus random call rounds against a SCAN reference model.
module tb_lift_call_panel;
  localparam int F = 7;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [F-1:0] btn = '0;
  logic [F-1:0] pending;
  logic         dir_up;

  lift_call_panel_if lif();

  lift_call_panel #(
    .FLOORS(F),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .lift(lif.master),
    .pending(pending),
    .dir_up(dir_up)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] tgt;
    logic       dir;
    logic [6:0] pend;
    int         lat;
    int         t0;
  } exp_t;

  exp_t q[$];
  exp_t cur_e;
  int total = 0;
  int passed = 0;

  logic [6:0] m_pend;
  logic       m_dir;
  logic [2:0] m_tgt;
  logic [6:0] mk;

  task automatic check(string name, int act, int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // SCAN rule from the floor numbers and pending set.
  task automatic predict(int lat, int t0);
    int c;
    int t;
    exp_t e;
    c = (lif.cur_floor == 3'd0) ? 1 : int'(lif.cur_floor);
    t = 0;
    if (m_dir) begin
      for (int f = c; f <= F; f++)
        if (t == 0 && m_pend[f-1]) t = f;
      if (t == 0) begin
        for (int f = c - 1; f >= 1; f--)
          if (t == 0 && m_pend[f-1]) t = f;
        m_dir = 1'b0;
      end
    end else begin
      for (int f = c; f >= 1; f--)
        if (t == 0 && m_pend[f-1]) t = f;
      if (t == 0) begin
        for (int f = c + 1; f <= F; f++)
          if (t == 0 && m_pend[f-1]) t = f;
        m_dir = 1'b1;
      end
    end
    e.tgt  = 3'(t);
    e.dir  = m_dir;
    e.pend = m_pend;
    e.lat  = lat;
    e.t0   = t0;
    q.push_back(e);
    m_tgt = 3'(t);
  endtask

  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (lif.target_valid && !prev_v) begin
      if (q.size() == 0) begin
        check("unexpected_offer", int'(lif.target), 0);
      end else begin
        cur_e = q.pop_front();
        check("offer_target", int'(lif.target), int'(cur_e.tgt));
        check("offer_dir", int'(dir_up), int'(cur_e.dir));
        check("offer_pending", int'(pending), int'(cur_e.pend));
        if (cur_e.lat >= 0)
          check("offer_latency", cyc - cur_e.t0, cur_e.lat);
      end
    end else if (lif.target_valid) begin
      check("offer_hold", int'(lif.target), int'(cur_e.tgt));
    end
    prev_v = lif.target_valid;
  end

  task automatic press(logic [6:0] m);
    btn = btn | m;
    tick(6);
    btn = btn & ~m;
    tick(8);
  endtask

  task automatic wait_offer();
    int n;
    n = 0;
    while (!lif.target_valid && n < 60) begin
      tick(1);
      n++;
    end
    if (!lif.target_valid) begin
      check("offer_timeout", 0, 1);
      finish_run();
    end
  endtask

  task automatic do_ack(logic arr);
    lif.target_ack = 1'b1;
    lif.arrived    = arr;
    tick(1);
    lif.target_ack = 1'b0;
    lif.arrived    = 1'b0;
    check("ack_drops_valid", int'(lif.target_valid), 0);
  endtask

  task automatic do_arrive(logic [2:0] fl);
    lif.cur_floor = fl;
    lif.arrived   = 1'b1;
    m_pend = m_pend & ~(7'(1) << (m_tgt - 3'd1));
    if (m_pend != '0) predict(-1, 0);
    tick(1);
    lif.arrived = 1'b0;
    check("arrive_target_zero", int'(lif.target), 0);
  endtask

  task automatic serve_all(bit rnd);
    logic [6:0] m;
    while (m_pend != '0) begin
      wait_offer();
      if (rnd) begin
        tick($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) begin
          lif.arrived = 1'b1;
          tick(1);
          lif.arrived = 1'b0;
        end
        if ($urandom_range(0, 3) == 0) begin
          m = 7'($urandom_range(1, 127));
          m_pend = m_pend | m;
          press(m);
        end
      end
      do_ack(rnd ? 1'($urandom_range(0, 1)) : 1'b0);
      if (rnd && $urandom_range(0, 2) == 0) begin
        m = 7'($urandom_range(1, 127));
        m_pend = m_pend | m;
        press(m);
      end
      if (rnd) tick($urandom_range(0, 3));
      if (rnd && $urandom_range(0, 4) == 0)
        do_arrive(3'($urandom_range(0, 7)));
      else
        do_arrive(m_tgt);
    end
  endtask

  initial begin
    lif.target_ack = 1'b0;
    lif.arrived    = 1'b0;
    lif.cur_floor  = 3'd1;
    btn   = 7'h7F;
    rst_n = 1'b0;
    tick(3);
    check("rst_target", int'(lif.target), 0);
    check("rst_valid", int'(lif.target_valid), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_dir", int'(dir_up), 1);

    // Buttons held through reset register after debounce.
    rst_n  = 1'b1;
    m_pend = 7'h7F;
    m_dir  = 1'b1;
    predict(-1, 0);
    tick(5);
    check("pre_debounce_pending", int'(pending), 0);
    check("pre_debounce_valid", int'(lif.target_valid), 0);
    tick(15);
    btn = '0;
    tick(8);
    serve_all(1'b0);

    lif.cur_floor = 3'd1;
    btn[4] = 1'b1;
    tick(3);
    btn[4] = 1'b0;
    m_pend = 7'b0000100;
    predict(8, cyc);
    press(7'b0000100);
    serve_all(1'b0);

    lif.cur_floor = 3'd4;
    m_pend = 7'b0100010;
    predict(-1, 0);
    press(7'b0100010);
    serve_all(1'b0);

    lif.cur_floor = 3'd5;
    m_pend = 7'b0010000;
    predict(-1, 0);
    press(7'b0010000);
    wait_offer();
    lif.arrived = 1'b1;
    tick(1);
    lif.arrived = 1'b0;
    check("stray_arrive_target", int'(lif.target), 5);
    check("stray_arrive_valid", int'(lif.target_valid), 1);
    m_pend = m_pend | 7'b0000001;
    press(7'b0000001);
    check("hold_target", int'(lif.target), 5);
    check("hold_valid", int'(lif.target_valid), 1);
    do_ack(1'b0);
    do_arrive(3'd5);
    serve_all(1'b0);

    lif.cur_floor = 3'd3;
    m_pend = 7'b0000100;
    predict(-1, 0);
    press(7'b0000100);
    wait_offer();
    do_ack(1'b0);
    btn[2] = 1'b1;
    tick(6);
    lif.arrived = 1'b1;
    tick(1);
    lif.arrived = 1'b0;
    m_pend = '0;
    check("set_clear_pending", int'(pending), 0);
    check("set_clear_target", int'(lif.target), 0);
    tick(2);
    check("set_clear_idle", int'(lif.target_valid), 0);
    btn[2] = 1'b0;
    tick(8);

    lif.target_ack = 1'b1;
    tick(1);
    lif.target_ack = 1'b0;
    tick(2);
    check("stray_ack_valid", int'(lif.target_valid), 0);
    check("stray_ack_target", int'(lif.target), 0);
    check("stray_ack_pending", int'(pending), 0);

    for (int r = 0; r < 25; r++) begin
      lif.cur_floor = 3'($urandom_range(0, 7));
      mk = 7'($urandom_range(1, 127));
      m_pend = mk;
      predict(8, cyc);
      press(mk);
      serve_all(1'b1);
      tick(2);
      check("round_idle_pending", int'(pending), 0);
      check("round_idle_valid", int'(lif.target_valid), 0);
    end

    tick(4);
    check("queue_empty", q.size(), 0);
    finish_run();
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

endmodule
